regs_test_driver: RTL and testbench

//  Initiator side of the register-file port: drives the write port (Write_Reg/W_Addr/W_Data) and both read-address ports.
//  On Start, writes a deterministic pattern into every register, then reads every register back through ports A and B.

---
 rtl/regs_test_driver_pkg.sv | 11 +
 rtl/regs_pattern_gen.sv | 14 +
 rtl/regs_test_driver.sv | 117 +++++++++++
 tb/tb_regs_test_driver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regs_test_driver_pkg.sv
// regs_test_driver_pkg: shared FSM encoding, pattern defaults and the pattern function
// used by the register-file self-test driver.
package regs_test_driver_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
   localparam logic [31:0] PAT_SEED_DEF = 32'h0000_000F;
   localparam logic [31:0] PAT_STEP_DEF = 32'h0101_0101;
   function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] step,
                                       input logic [31:0] idx);
      return seed + idx * step;
   endfunction
endpackage

// File: rtl/regs_pattern_gen.sv
// regs_pattern_gen: combinational test pattern for one register address.
module regs_pattern_gen
   import regs_test_driver_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter logic [DATA_W-1:0] PAT_SEED = DATA_W'(PAT_SEED_DEF),
   parameter logic [DATA_W-1:0] PAT_STEP = DATA_W'(PAT_STEP_DEF)
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] pat_o
);
   assign pat_o = DATA_W'(pat(32'(PAT_SEED), 32'(PAT_STEP), 32'(addr_i)));
endmodule

// File: rtl/regs_test_driver.sv
// regs_test_driver: writes a pattern into every register, reads it back on two ports,
// latches the first mismatch and shows status on the LEDs.
module regs_test_driver
   import regs_test_driver_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter logic [DATA_W-1:0] PAT_SEED = DATA_W'(PAT_SEED_DEF),
   parameter logic [DATA_W-1:0] PAT_STEP = DATA_W'(PAT_STEP_DEF)
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        MUX,
   output logic              Write_Reg,
   output logic [ADDR_W-1:0] W_Addr,
   output logic [DATA_W-1:0] W_Data,
   output logic [ADDR_W-1:0] R_Addr_A,
   output logic [ADDR_W-1:0] R_Addr_B,
   input  logic [DATA_W-1:0] R_Data_A,
   input  logic [DATA_W-1:0] R_Data_B,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [ADDR_W-1:0] Err_Addr,
   output logic [7:0]        LED
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   state_t state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, w_addr_q, w_addr_d, ra_q, ra_d, rb_q, rb_d, err_addr_q, err_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d, pat_w, pat_a, pat_b;
   logic wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [7:0] led_q, led_d;
   logic start_run, wr_last, rd_last, chk, mis_a, mis_b;

   regs_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAT_SEED(PAT_SEED), .PAT_STEP(PAT_STEP))
      u_pat_w (.addr_i(w_addr_d), .pat_o(pat_w));
   regs_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAT_SEED(PAT_SEED), .PAT_STEP(PAT_STEP))
      u_pat_a (.addr_i(ra_q), .pat_o(pat_a));
   regs_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAT_SEED(PAT_SEED), .PAT_STEP(PAT_STEP))
      u_pat_b (.addr_i(rb_q), .pat_o(pat_b));

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         led_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         w_addr_q   <= w_addr_d;
         w_data_q   <= w_data_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         led_q      <= led_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (Start) state_d = WRITE;
         WRITE:      if (cnt_q == LAST) state_d = READ;
         READ:       if (cnt_q == LAST) state_d = DONE;
      endcase
   end

   // In READ, cnt_q tracks R_Addr_A so one comparator ends both phases.
   always_comb begin
      start_run  = (state_q == IDLE || state_q == DONE) && Start;
      wr_last    = state_q == WRITE && cnt_q == LAST;
      rd_last    = state_q == READ && cnt_q == LAST;
      cnt_d      = (start_run || wr_last || rd_last) ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
      wr_d       = start_run || (state_q == WRITE && !wr_last);
      w_addr_d   = start_run ? '0 : wr_d ? cnt_q + 1'b1 : w_addr_q;
      w_data_d   = wr_d ? pat_w : w_data_q;
      ra_d       = wr_last ? '0 : (state_q == READ && !rd_last) ? ra_q + 1'b1 : ra_q;
      rb_d       = wr_last ? LAST : (state_q == READ && !rd_last) ? rb_q - 1'b1 : rb_q;
      chk        = state_q == READ && !err_q;
      mis_a      = R_Data_A != pat_a;
      mis_b      = R_Data_B != pat_b;
      err_d      = start_run ? 1'b0 : err_q || (chk && (mis_a || mis_b));
      err_addr_d = start_run ? '0 : (chk && mis_a) ? ra_q : (chk && mis_b) ? rb_q : err_addr_q;
      busy_d     = state_d == WRITE || state_d == READ;
      done_d     = state_d == DONE;
      led_d      = MUX == 2'b00 ? {done_q, err_q, 1'b0, err_addr_q[4:0]} :
                   MUX == 2'b01 ? {3'b000, cnt_q[4:0]} :
                   MUX == 2'b10 ? R_Data_A[7:0] : R_Data_A[15:8];
   end

   assign Write_Reg = wr_q;
   assign W_Addr    = w_addr_q;
   assign W_Data    = w_data_q;
   assign R_Addr_A  = ra_q;
   assign R_Addr_B  = rb_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Err       = err_q;
   assign Err_Addr  = err_addr_q;
   assign LED       = led_q;
endmodule

// File: tb/tb_regs_test_driver.sv
// tb_regs_test_driver: directed bench with behavioural negedge-write register files
// for a 32-register and an 8-register driver instance.
module tb_regs_test_driver;
   logic CLK = 1'b0, Reset = 1'b0, Start = 1'b0, Start8 = 1'b0, clr = 1'b0;
   logic [1:0] MUX = 2'b00;
   logic [31:0] bad = '0;
   always #5 CLK = ~CLK;

   logic wr, busy, done, err, wr8, busy8, done8, err8;
   logic [4:0] waddr, ra, rb, eaddr, waddr8, ra8, rb8, eaddr8;
   logic [31:0] wdata, rda, rdb, wdata8, rda8, rdb8;
   logic [7:0] led, led8;
   logic [31:0] rf [32];
   logic [31:0] rf8 [8];

   always @(negedge CLK) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
         for (int i = 0; i < 8; i++) rf8[i] <= '0;
      end else begin
         if (wr) rf[waddr] <= wdata;
         if (wr8) rf8[waddr8[2:0]] <= wdata8;
      end
   end
   assign rda  = rf[ra] ^ (bad[ra] ? 32'hDEAD_0000 : 32'h0);
   assign rdb  = rf[rb] ^ (bad[rb] ? 32'hDEAD_0000 : 32'h0);
   assign rda8 = rf8[ra8[2:0]];
   assign rdb8 = rf8[rb8[2:0]];

   regs_test_driver dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .MUX(MUX), .Write_Reg(wr), .W_Addr(waddr),
      .W_Data(wdata), .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(rda), .R_Data_B(rdb),
      .Busy(busy), .Done(done), .Err(err), .Err_Addr(eaddr), .LED(led));

   regs_test_driver #(.NUM_REGS(8)) dut8 (
      .CLK(CLK), .Reset(Reset), .Start(Start8), .MUX(MUX), .Write_Reg(wr8), .W_Addr(waddr8),
      .W_Data(wdata8), .R_Addr_A(ra8), .R_Addr_B(rb8), .R_Data_A(rda8), .R_Data_B(rdb8),
      .Busy(busy8), .Done(done8), .Err(err8), .Err_Addr(eaddr8), .LED(led8));

   int checks = 0, fails = 0;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Runs one test on the 32-register instance; returns write count, cycle Done rose, and flags.
   task automatic run_full(input bit hold, output int nwr, output int dcyc, output bit wr_ok,
                           output bit busy_ok, output bit e1);
      nwr = 0; dcyc = 0; wr_ok = 1'b1; busy_ok = 1'b1; e1 = 1'b1;
      Start = 1'b1;
      for (int p = 1; p <= 100 && dcyc == 0; p++) begin
         tick;
         if (!hold) Start = 1'b0;
         if (p == 1) e1 = err;
         if (busy !== (p <= 64)) busy_ok = 1'b0;
         if (wr) begin
            nwr++;
            if (waddr !== 5'(p - 1) || wdata !== 32'h0000_000F + 32'(p - 1) * 32'h0101_0101) wr_ok = 1'b0;
            if (waddr == 5'd5 && wdata !== 32'h0505_0514) wr_ok = 1'b0;
         end
         if (done) dcyc = p;
      end
      Start = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b0; clr = 1'b1;
      repeat (3) tick;
      checks++; if ({wr, busy, done, err} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b exp 0000", {wr, busy, done, err}); end
      checks++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led: got %h exp 00", led); end
      checks++; if ({waddr, wdata, ra, rb, eaddr} !== '0) begin fails++; $display("FAIL reset_addr_data: got nonzero exp 0"); end
      clr = 1'b0; Reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick;
         checks++; if ({wr, busy, done} !== 3'b0) begin fails++; $display("FAIL idle_c%0d: got %b exp 000", c, {wr, busy, done}); end
      end
   endtask

   task automatic test_basic_run;
      int nwr, dcyc; bit wr_ok, busy_ok, e1;
      MUX = 2'b00;
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      checks++; if (nwr != 32) begin fails++; $display("FAIL basic_nwr: got %0d exp 32", nwr); end
      checks++; if (dcyc != 65) begin fails++; $display("FAIL basic_done_cycle: got %0d exp 65", dcyc); end
      checks++; if (!wr_ok) begin fails++; $display("FAIL basic_wr_addr_data: got bad exp ok"); end
      checks++; if (!busy_ok) begin fails++; $display("FAIL basic_busy: got bad exp ok"); end
      tick;
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b exp 0", err); end
      checks++; if (led !== 8'h80) begin fails++; $display("FAIL basic_led: got %h exp 80", led); end
   endtask

   task automatic test_corrupt;
      int nwr, dcyc; bit wr_ok, busy_ok, e1;
      bad = 32'h0000_0080;
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      tick;
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL corrupt7_err: got %b exp 1", err); end
      checks++; if (eaddr !== 5'd7) begin fails++; $display("FAIL corrupt7_addr: got %0d exp 7", eaddr); end
      checks++; if (led !== 8'hC7) begin fails++; $display("FAIL corrupt7_led: got %h exp c7", led); end
      bad = 32'h0100_0080;
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      tick;
      checks++; if (eaddr !== 5'd7) begin fails++; $display("FAIL corrupt7_24_addr: got %0d exp 7", eaddr); end
      bad = 32'h0100_0000;
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      tick;
      checks++; if (eaddr !== 5'd24) begin fails++; $display("FAIL corrupt24_addr: got %0d exp 24", eaddr); end
      bad = '0;
   endtask

   task automatic test_hold_start;
      int nwr, dcyc; bit wr_ok, busy_ok, e1;
      run_full(1'b1, nwr, dcyc, wr_ok, busy_ok, e1);
      checks++; if (e1 !== 1'b0) begin fails++; $display("FAIL hold_err_cleared: got %b exp 0", e1); end
      checks++; if (nwr != 32) begin fails++; $display("FAIL hold_nwr: got %0d exp 32", nwr); end
      checks++; if (dcyc != 65) begin fails++; $display("FAIL hold_done_cycle: got %0d exp 65", dcyc); end
      tick;
      checks++; if ({done, busy, err} !== 3'b100) begin fails++; $display("FAIL hold_done_state: got %b exp 100", {done, busy, err}); end
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      checks++; if (nwr != 32 || !wr_ok) begin fails++; $display("FAIL restart_nwr: got %0d exp 32", nwr); end
   endtask

   task automatic test_mid_reset;
      int nwr, dcyc; bit wr_ok, busy_ok, e1;
      MUX = 2'b01;
      Start = 1'b1; tick; Start = 1'b0;
      repeat (9) tick;
      checks++; if ({wr, busy, led} !== {2'b11, 8'h08}) begin fails++; $display("FAIL midrst_pre: got %b/%h exp 11/08", {wr, busy}, led); end
      Reset = 1'b0; #1;
      checks++; if ({wr, busy} !== 2'b00) begin fails++; $display("FAIL midrst_drop: got %b exp 00", {wr, busy}); end
      checks++; if (led !== 8'h00) begin fails++; $display("FAIL midrst_led: got %h exp 00", led); end
      tick; Reset = 1'b1; tick;
      checks++; if ({wr, busy, done} !== 3'b000) begin fails++; $display("FAIL midrst_idle: got %b exp 000", {wr, busy, done}); end
      run_full(1'b0, nwr, dcyc, wr_ok, busy_ok, e1);
      tick;
      checks++; if (nwr != 32 || dcyc != 65 || err !== 1'b0) begin fails++; $display("FAIL midrst_rerun: got nwr=%0d done=%0d err=%b exp 32/65/0", nwr, dcyc, err); end
   endtask

   task automatic test_eight_regs;
      int n8 = 0, d8 = 0; bit ok = 1'b1;
      MUX = 2'b01;
      Start8 = 1'b1;
      for (int p = 1; p <= 40 && d8 == 0; p++) begin
         tick;
         Start8 = 1'b0;
         if (wr8) begin n8++; if (waddr8 !== 5'(p - 1)) ok = 1'b0; end
         if (p >= 2 && p <= 9) begin
            checks++; if (led8 !== 8'(p - 2)) begin fails++; $display("FAIL n8_cnt_led_p%0d: got %h exp %h", p, led8, 8'(p - 2)); end
         end
         if (done8) d8 = p;
      end
      checks++; if (n8 != 8 || !ok) begin fails++; $display("FAIL n8_writes: got %0d exp 8", n8); end
      checks++; if (d8 != 17) begin fails++; $display("FAIL n8_done_cycle: got %0d exp 17", d8); end
      checks++; if (err8 !== 1'b0) begin fails++; $display("FAIL n8_err: got %b exp 0", err8); end
   endtask

   initial begin
      test_reset;
      test_basic_run;
      test_corrupt;
      test_hold_start;
      test_mid_reset;
      test_eight_regs;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
